// File: rtl/dm_abstract_cmd.sv
// Abstract-command engine: executes Access Register commands against the hart's
// GPR file or CSR space over two request/acknowledge ports and reports busy/cmderr.
module dm_abstract_cmd #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iCmdValid,
  input  logic [31:0] iCommand,
  input  logic [31:0] iData0,
  input  logic        iHalted,
  input  logic        iClearErr,
  output logic        oBusy,
  output logic [2:0]  oCmdErr,
  output logic        oData0Valid,
  output logic [31:0] oData0,
  output logic        oRfReq,
  output logic        oRfWe,
  output logic [4:0]  oRfAddr,
  output logic [31:0] oRfWdata,
  input  logic        iRfAck,
  input  logic [31:0] iRfRdata,
  output logic        oCsrReq,
  output logic        oCsrWe,
  output logic [11:0] oCsrAddr,
  output logic [31:0] oCsrWdata,
  input  logic        iCsrAck,
  input  logic        iCsrErr,
  input  logic [31:0] iCsrRdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_BUSY   = 3'd1;
  localparam logic [2:0] ERR_NOTSUP = 3'd2;
  localparam logic [2:0] ERR_EXC    = 3'd3;
  localparam logic [2:0] ERR_HALT   = 3'd4;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q,   state_d;
  logic              tgt_csr_q, tgt_csr_d;
  logic              we_q,      we_d;
  logic [11:0]       addr_q,    addr_d;
  logic [31:0]       wdata_q,   wdata_d;
  logic [31:0]       rdata_q,   rdata_d;
  logic              rd_ok_q,   rd_ok_d;
  logic [TO_W-1:0]   to_cnt_q,  to_cnt_d;
  logic [2:0]        cmderr_q,  cmderr_d;

  // Command word fields
  logic [7:0]  cmdtype;
  logic [2:0]  aarsize;
  logic        postexec;
  logic        transfer;
  logic        is_write;
  logic [15:0] regno;
  logic        unused_cmd_bits;

  assign cmdtype         = iCommand[31:24];
  assign aarsize         = iCommand[22:20];
  assign postexec        = iCommand[18];
  assign transfer        = iCommand[17];
  assign is_write        = iCommand[16];
  assign regno           = iCommand[15:0];
  assign unused_cmd_bits = ^{iCommand[23], iCommand[19]};

  logic regno_csr;
  logic regno_gpr;
  logic busy;
  logic busy_err;
  logic ack_sel;
  logic fsm_err;
  logic [2:0] fsm_err_code;

  assign regno_csr = (regno[15:12] == 4'h0);
  assign regno_gpr = (regno[15:5] == 11'h080);
  assign busy      = (state_q != IDLE);
  assign busy_err  = iCmdValid && busy;
  assign ack_sel   = tgt_csr_q ? iCsrAck : iRfAck;

  always_comb begin
    state_d      = state_q;
    tgt_csr_d    = tgt_csr_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rd_ok_d      = rd_ok_q;
    to_cnt_d     = to_cnt_q;
    fsm_err      = 1'b0;
    fsm_err_code = ERR_NONE;

    unique case (state_q)
      IDLE: begin
        // A pending error locks out new commands until the debugger clears it
        if (iCmdValid && (cmderr_q == ERR_NONE)) begin
          if (cmdtype != 8'h00) begin
            fsm_err      = 1'b1;
            fsm_err_code = ERR_NOTSUP;
          end else if (!transfer && !postexec) begin
            state_d = IDLE;
          end else if ((aarsize != 3'd2) || postexec) begin
            fsm_err      = 1'b1;
            fsm_err_code = ERR_NOTSUP;
          end else if (!regno_csr && !regno_gpr) begin
            fsm_err      = 1'b1;
            fsm_err_code = ERR_NOTSUP;
          end else if (!iHalted) begin
            fsm_err      = 1'b1;
            fsm_err_code = ERR_HALT;
          end else begin
            state_d   = REQ;
            tgt_csr_d = regno_csr;
            addr_d    = regno_csr ? regno[11:0] : {7'd0, regno[4:0]};
            we_d      = is_write;
            wdata_d   = iData0;
            rd_ok_d   = 1'b0;
            to_cnt_d  = '0;
          end
        end
      end

      REQ: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (ack_sel) begin
          state_d = DONE;
          if (tgt_csr_q && iCsrErr) begin
            fsm_err      = 1'b1;
            fsm_err_code = ERR_EXC;
          end else if (!we_q) begin
            rdata_d = tgt_csr_q ? iCsrRdata : iRfRdata;
            rd_ok_d = 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // Nobody answered: abandon the request
          state_d      = DONE;
          fsm_err      = 1'b1;
          fsm_err_code = ERR_EXC;
        end
      end

      DONE: begin
        state_d = IDLE;
        rd_ok_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // Busy collision outranks the in-flight command's own error; errors outrank clear
  always_comb begin
    cmderr_d = cmderr_q;
    if ((cmderr_q == ERR_NONE) && busy_err) begin
      cmderr_d = ERR_BUSY;
    end else if ((cmderr_q == ERR_NONE) && fsm_err) begin
      cmderr_d = fsm_err_code;
    end else if (iClearErr && !busy) begin
      cmderr_d = ERR_NONE;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= IDLE;
      tgt_csr_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_ok_q   <= 1'b0;
      to_cnt_q  <= '0;
      cmderr_q  <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      tgt_csr_q <= tgt_csr_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rd_ok_q   <= rd_ok_d;
      to_cnt_q  <= to_cnt_d;
      cmderr_q  <= cmderr_d;
    end
  end

  // Port outputs are qualified by the request so idle ports read as zero
  logic rf_req;
  logic csr_req;

  assign rf_req  = (state_q == REQ) && !tgt_csr_q;
  assign csr_req = (state_q == REQ) && tgt_csr_q;

  assign oBusy       = busy;
  assign oCmdErr     = cmderr_q;
  assign oData0Valid = (state_q == DONE) && rd_ok_q;
  assign oData0      = rdata_q;

  assign oRfReq    = rf_req;
  assign oRfWe     = rf_req && we_q;
  assign oRfAddr   = rf_req ? addr_q[4:0] : 5'd0;
  assign oRfWdata  = rf_req ? wdata_q : 32'd0;

  assign oCsrReq   = csr_req;
  assign oCsrWe    = csr_req && we_q;
  assign oCsrAddr  = csr_req ? addr_q : 12'd0;
  assign oCsrWdata = csr_req ? wdata_q : 32'd0;

endmodule
